mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the 32x8 synchronous `mem` block, whose reads and writes both complete on posedge.
- Port 0 is the CPU data/fetch requester. Port 1 is the loader/debug requester.
- Serialises requests onto the single mem command interface, never drives read and write together, and returns the one-cycle-latency read data to the winning requester with an ack pulse.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_chk.sv | 17 +
 rtl/rr_arb2.sv | 36 +++
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int MEM_AW = 5;
    localparam int MEM_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // One requester's access, as captured into the command registers.
    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_chk.sv
// Protocol checker for mem_arbiter outputs.
module mem_arbiter_chk (
    input logic clk,
    input logic rst_,
    input logic mem_read,
    input logic mem_write,
    input logic ack0,
    input logic ack1
);

    a_rw_excl: assert property (@(posedge clk) disable iff (!rst_) !(mem_read && mem_write))
        else $error("mem_read and mem_write high together");

    a_ack_excl: assert property (@(posedge clk) disable iff (!rst_) !(ack0 && ack1))
        else $error("ack0 and ack1 high together");

endmodule

// File: rtl/rr_arb2.sv
// Two-input arbiter: combinational grant, last-grant pointer updated on enable.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_,
    input  logic       fixed_pri,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_r;   // 1 = port 1 won the most recent grant

    // Grant: a lone requester wins; a tie goes to port 0 under fixed priority, else to the port that did not win last
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            if (fixed_pri || last_r) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else begin
            gnt = req;
        end
    end

    // Pointer starts at "last = port 1" so port 0 wins the first tie
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            last_r <= 1'b1;
        end else if (en && (gnt != 2'b00)) begin
            last_r <= gnt[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the 32x8 synchronous mem block.
// IDLE -> CMD (command on pins one cycle) -> RESP (ack + read data), with
// back-to-back issue of the other port straight out of RESP.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = MEM_AW,
    parameter int DW        = MEM_DW,
    parameter int FIXED_PRI = 0
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    arb_state_t    state_r, state_nxt_s;
    logic [1:0]    arb_req_s, gnt_s;
    logic          arb_en_s, issue_s;
    mem_req_t      win_s;   // AW/DW must equal MEM_AW/MEM_DW
    logic          mem_read_r, mem_write_r, ack0_r, ack1_r, busy_r, owner_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r, rdata0_r, rdata1_r;

    // Which requests may compete this cycle; in RESP the completing owner still holds req and is masked
    always_comb begin
        arb_req_s = 2'b00;
        arb_en_s  = 1'b0;
        case (state_r)
            IDLE: begin
                arb_req_s = {req1, req0};
                arb_en_s  = 1'b1;
            end
            RESP: begin
                if (owner_r) begin
                    arb_req_s = {1'b0, req0};
                end else begin
                    arb_req_s = {req1, 1'b0};
                end
                arb_en_s = 1'b1;
            end
            CMD: begin
                arb_en_s = 1'b0;
            end
            default: begin
                arb_en_s = 1'b0;
            end
        endcase
    end

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_      (rst_),
        .fixed_pri ((FIXED_PRI != 0) ? 1'b1 : 1'b0),
        .req       (arb_req_s),
        .en        (issue_s),
        .gnt       (gnt_s)
    );

    // Next state and the winning port's access fields
    always_comb begin
        issue_s     = arb_en_s && (gnt_s != 2'b00);
        state_nxt_s = state_r;
        if (gnt_s[1]) begin
            win_s = '{we: we1, addr: addr1, wdata: wdata1};
        end else begin
            win_s = '{we: we0, addr: addr0, wdata: wdata0};
        end
        case (state_r)
            IDLE, RESP: begin
                if (issue_s) begin
                    state_nxt_s = CMD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CMD:     state_nxt_s = RESP;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command registers: load on issue, drop the strobe after its single CMD cycle
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            owner_r     <= 1'b0;
        end else if (issue_s) begin
            mem_read_r  <= !win_s.we;
            mem_write_r <= win_s.we;
            mem_addr_r  <= win_s.addr;
            mem_wdata_r <= win_s.wdata;
            owner_r     <= gnt_s[1];
        end else if (state_r == CMD) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end
    end

    // Ack pulse for the owner during RESP, and busy whenever the next state is not IDLE
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            ack0_r <= (state_r == CMD) && !owner_r;
            ack1_r <= (state_r == CMD) && owner_r;
            busy_r <= (state_nxt_s != IDLE);
        end
    end

    // Per-port read data hold, captured at the end of that port's RESP
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rdata0_r <= '0;
            rdata1_r <= '0;
        end else if (state_r == RESP) begin
            if (owner_r) begin
                rdata1_r <= mem_rdata;
            end else begin
                rdata0_r <= mem_rdata;
            end
        end
    end

    // Owning port sees mem_rdata directly in RESP; the other keeps its previous value
    always_comb begin
        if ((state_r == RESP) && !owner_r) begin
            rdata0 = mem_rdata;
        end else begin
            rdata0 = rdata0_r;
        end
        if ((state_r == RESP) && owner_r) begin
            rdata1 = mem_rdata;
        end else begin
            rdata1 = rdata1_r;
        end
    end

    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign busy      = busy_r;
    assign owner     = owner_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed literals.
module tb_mem_arbiter;

    logic       clk, rst_;
    logic       rq[2], wr[2];
    logic [4:0] ad[2];
    logic [7:0] wd[2];
    logic       ack0, ack1, mem_read, mem_write, busy, owner;
    logic [7:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [4:0] mem_addr;

    logic       frq[2], fwe[2];
    logic [4:0] fad[2];
    logic [7:0] fwd[2];
    logic       f_ack0, f_ack1, f_mem_read, f_mem_write, f_busy, f_owner;
    logic [7:0] f_rdata0, f_rdata1, f_mem_wdata, f_mem_rdata;
    logic [4:0] f_mem_addr;

    logic [7:0] envmem[32];
    logic [7:0] init_mem[32];
    logic       pre_load;

    mem_arbiter #(.AW(5), .DW(8), .FIXED_PRI(0)) dut (
        .clk(clk), .rst_(rst_),
        .req0(rq[0]), .we0(wr[0]), .addr0(ad[0]), .wdata0(wd[0]), .ack0(ack0), .rdata0(rdata0),
        .req1(rq[1]), .we1(wr[1]), .addr1(ad[1]), .wdata1(wd[1]), .ack1(ack1), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_arbiter #(.AW(5), .DW(8), .FIXED_PRI(1)) dut_fix (
        .clk(clk), .rst_(rst_),
        .req0(frq[0]), .we0(fwe[0]), .addr0(fad[0]), .wdata0(fwd[0]), .ack0(f_ack0), .rdata0(f_rdata0),
        .req1(frq[1]), .we1(fwe[1]), .addr1(fad[1]), .wdata1(fwd[1]), .ack1(f_ack1), .rdata1(f_rdata1),
        .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_rdata(f_mem_rdata), .busy(f_busy), .owner(f_owner)
    );

    mem_arbiter_chk u_chk (.clk(clk), .rst_(rst_), .mem_read(mem_read), .mem_write(mem_write),
                           .ack0(ack0), .ack1(ack1));
    mem_arbiter_chk u_chk_fix (.clk(clk), .rst_(rst_), .mem_read(f_mem_read), .mem_write(f_mem_write),
                               .ack0(f_ack0), .ack1(f_ack1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous 32x8 memory: read and write complete on posedge
    always @(posedge clk) begin
        if (pre_load) begin
            for (int i = 0; i < 32; i++) envmem[i] <= init_mem[i];
        end else begin
            if (mem_write) envmem[mem_addr] <= mem_wdata;
            if (mem_read)  mem_rdata <= envmem[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int         cmdc;   // cycle the command sits on the mem pins
        bit         port;
        bit         we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
    } acc_t;

    acc_t       q[$];
    logic [7:0] shadow[32];
    int         cyc, total, passed;
    bit         last_win, exp_owner;
    bit         granted[2], just_acked[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        q.delete();
        last_win   = 1'b1;
        exp_owner  = 1'b0;
        granted    = '{1'b0, 1'b0};
        just_acked = '{1'b0, 1'b0};
    endtask

    // Compare every DUT output that the model defines for this cycle
    task automatic check_outputs();
        logic e_rd, e_wr, e_busy;
        logic e_ack[2];
        e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        foreach (q[i]) begin
            if (q[i].cmdc == cyc) begin
                e_rd = !q[i].we; e_wr = q[i].we; e_busy = 1'b1; exp_owner = q[i].port;
                chk("mem_addr", 32'(mem_addr), 32'(q[i].addr));
                if (q[i].we) chk("mem_wdata", 32'(mem_wdata), 32'(q[i].wdata));
            end else if (q[i].cmdc + 1 == cyc) begin
                e_ack[q[i].port] = 1'b1; e_busy = 1'b1;
                if (!q[i].we) begin
                    if (q[i].port) chk("rdata1", 32'(rdata1), 32'(q[i].rd));
                    else           chk("rdata0", 32'(rdata0), 32'(q[i].rd));
                end
            end
        end
        chk("mem_read", 32'(mem_read), 32'(e_rd));
        chk("mem_write", 32'(mem_write), 32'(e_wr));
        chk("ack0", 32'(ack0), 32'(e_ack[0]));
        chk("ack1", 32'(ack1), 32'(e_ack[1]));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("owner", 32'(owner), 32'(exp_owner));
    endtask

    // Decide whether an access is granted from this cycle's requests
    task automatic arbitrate();
        bit   incmd, r0, r1, w;
        int   mask;
        acc_t a;
        incmd = 1'b0; mask = -1;
        if (rst_) begin
            foreach (q[i]) begin
                if (q[i].cmdc == cyc)     incmd = 1'b1;
                if (q[i].cmdc + 1 == cyc) mask = int'(q[i].port);
            end
            if (!incmd) begin
                r0 = rq[0] && (mask != 0);
                r1 = rq[1] && (mask != 1);
                if (r0 || r1) begin
                    if (r0 && r1) w = !last_win;
                    else          w = r1;
                    last_win = w;
                    a.cmdc = cyc + 1; a.port = w; a.we = wr[w];
                    a.addr = ad[w]; a.wdata = wd[w]; a.rd = 8'h00;
                    q.push_back(a);
                    granted[w] = 1'b1;
                end
            end
        end
    endtask

    // One clock: check at negedge, arbitrate, then advance past posedge
    task automatic step();
        @(negedge clk);
        check_outputs();
        arbitrate();
        @(posedge clk);
        foreach (q[i]) begin
            if ((q[i].cmdc == cyc) && rst_) begin
                if (q[i].we) shadow[q[i].addr] = q[i].wdata;
                else         q[i].rd = shadow[q[i].addr];
            end
        end
        cyc++;
        while (q.size() > 0 && q[0].cmdc + 1 < cyc) begin
            just_acked[q[0].port] = 1'b1;
            granted[q[0].port]    = 1'b0;
            void'(q.pop_front());
        end
        #1;
    endtask

    task automatic wait_ack(input int p, output int lat, output int rd_cnt);
        int t;
        t = cyc; lat = -1; rd_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (mem_read) rd_cnt++;
            if ((p == 0) ? ack0 : ack1) begin
                lat = cyc - t;
                break;
            end
        end
    endtask

    task automatic fwait(input int p, output int lat);
        int t;
        t = cyc; lat = -1;
        for (int n = 0; n < 12; n++) begin
            step();
            chk("fix_no_read", 32'(f_mem_read), 32'(1'b0));
            if (f_mem_write) chk("fix_addr", 32'(f_mem_addr), 32'(fad[f_owner]));
            if (f_mem_write) chk("fix_wdata", 32'(f_mem_wdata), 32'(fwd[f_owner]));
            if ((p == 0 && f_ack0) || (p == 1 && f_ack1) || (p == 2 && (f_ack0 || f_ack1))) begin
                lat = cyc - t;
                break;
            end
        end
    endtask

    int ack_port[$], ack_t[$];
    int exp_p[4];
    int lat, rdc, t0, n_ack1;

    initial begin
        total = 0; passed = 0; cyc = 0;
        rst_ = 1'b0; pre_load = 1'b0; f_mem_rdata = 8'h00;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; wr[p] = 1'b0; ad[p] = 5'd0; wd[p] = 8'd0;
            frq[p] = 1'b0; fwe[p] = 1'b1; fwd[p] = 8'h5A + 8'(p);
        end
        fad[0] = 5'd4; fad[1] = 5'd20;
        for (int i = 0; i < 32; i++) begin
            init_mem[i] = 8'($urandom_range(255));
        end
        init_mem[7] = 8'hA5; init_mem[3] = 8'h11;
        for (int i = 0; i < 32; i++) shadow[i] = init_mem[i];
        model_reset();
        pre_load = 1'b1;
        @(posedge clk); #1;
        pre_load = 1'b0;

        // reset state
        chk("rst_mem_read", 32'(mem_read), 32'(1'b0));
        chk("rst_mem_write", 32'(mem_write), 32'(1'b0));
        chk("rst_ack0", 32'(ack0), 32'(1'b0));
        chk("rst_ack1", 32'(ack1), 32'(1'b0));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_owner", 32'(owner), 32'(1'b0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(5'd0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(8'd0));
        chk("rst_rdata0", 32'(rdata0), 32'(8'd0));
        chk("rst_rdata1", 32'(rdata1), 32'(8'd0));

        // round-robin tie, both reads held from reset
        rq[0] = 1'b1; ad[0] = 5'd1; rq[1] = 1'b1; ad[1] = 5'd2;
        rst_ = 1'b1; t0 = cyc;
        for (int n = 0; n < 9; n++) begin
            step();
            if (ack0) begin ack_port.push_back(0); ack_t.push_back(cyc - t0); end
            if (ack1) begin ack_port.push_back(1); ack_t.push_back(cyc - t0); end
        end
        exp_p = '{0, 1, 0, 1};
        chk("rr_ack_count", 32'(ack_port.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_port.size(); i++) begin
            chk("rr_order", 32'(ack_port[i]), 32'(exp_p[i]));
            chk("rr_time", 32'(ack_t[i]), 32'(2 * (i + 1)));
        end
        rq[0] = 1'b0; rq[1] = 1'b0;
        for (int n = 0; n < 5; n++) step();

        // single read of addr 7
        rq[0] = 1'b1; wr[0] = 1'b0; ad[0] = 5'd7;
        wait_ack(0, lat, rdc);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_data", 32'(rdata0), 32'(8'hA5));
        chk("rd_no_ack1", 32'(ack1), 32'(1'b0));
        chk("rd_one_cmd", 32'(rdc), 32'd1);
        rq[0] = 1'b0; step();

        // port 1 write then readback at addr 31
        rq[1] = 1'b1; wr[1] = 1'b1; ad[1] = 5'd31; wd[1] = 8'h3C;
        wait_ack(1, lat, rdc);
        chk("wr_latency", 32'(lat), 32'd2);
        chk("wr_mem31", 32'(envmem[31]), 32'(8'h3C));
        rq[1] = 1'b0; step();
        rq[1] = 1'b1; wr[1] = 1'b0;
        wait_ack(1, lat, rdc);
        chk("rb_latency", 32'(lat), 32'd2);
        chk("rb_data", 32'(rdata1), 32'(8'h3C));
        rq[1] = 1'b0; step();

        // withdrawn request: req1 high only during port 0's CMD cycle
        rq[0] = 1'b1; wr[0] = 1'b0; ad[0] = 5'd5;
        step();
        rq[1] = 1'b1; wr[1] = 1'b0; ad[1] = 5'd9;
        step();
        chk("wd_ack0", 32'(ack0), 32'(1'b1));
        rq[0] = 1'b0; rq[1] = 1'b0;
        n_ack1 = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (ack1) n_ack1++;
        end
        chk("wd_no_ack1", 32'(n_ack1), 32'd0);
        chk("wd_idle", 32'(busy), 32'(1'b0));

        // reset during the CMD cycle of a write of FF to addr 3
        rq[0] = 1'b1; wr[0] = 1'b1; ad[0] = 5'd3; wd[0] = 8'hFF;
        step();
        chk("mr_in_cmd", 32'(mem_write), 32'(1'b1));
        rst_ = 1'b0;
        #1;
        chk("mr_write", 32'(mem_write), 32'(1'b0));
        chk("mr_read", 32'(mem_read), 32'(1'b0));
        chk("mr_addr", 32'(mem_addr), 32'(5'd0));
        chk("mr_wdata", 32'(mem_wdata), 32'(8'd0));
        chk("mr_ack0", 32'(ack0), 32'(1'b0));
        chk("mr_busy", 32'(busy), 32'(1'b0));
        chk("mr_owner", 32'(owner), 32'(1'b0));
        rq[0] = 1'b0;
        model_reset();
        step(); step();
        chk("mr_mem3_kept", 32'(envmem[3]), 32'(8'h11));
        rst_ = 1'b1;
        rq[0] = 1'b1; wr[0] = 1'b0; ad[0] = 5'd12;
        rq[1] = 1'b1; wr[1] = 1'b0; ad[1] = 5'd13;
        t0 = cyc; lat = -1;
        for (int n = 0; n < 10; n++) begin
            step();
            if (ack0 || ack1) begin lat = cyc - t0; break; end
        end
        chk("mr_first_lat", 32'(lat), 32'd2);
        chk("mr_first_is0", 32'(ack0), 32'(1'b1));
        rq[0] = 1'b0; rq[1] = 1'b0;
        for (int n = 0; n < 6; n++) step();

        // randomized traffic against the model
        just_acked = '{1'b0, 1'b0};
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (just_acked[p]) begin
                    rq[p] = 1'b0; just_acked[p] = 1'b0;
                end else if (!rq[p]) begin
                    if ($urandom_range(2) == 0) begin
                        rq[p] = 1'b1;
                        wr[p] = 1'($urandom_range(1));
                        ad[p] = 5'($urandom_range(31));
                        wd[p] = 8'($urandom_range(255));
                    end
                end else if (!granted[p] && $urandom_range(7) == 0) begin
                    rq[p] = 1'b0;
                end
            end
            step();
        end
        rq[0] = 1'b0; rq[1] = 1'b0;
        for (int n = 0; n < 6; n++) step();

        // fixed priority: after port 0 wins alone, a tie still goes to port 0
        for (int r = 0; r < 2; r++) begin
            frq[0] = 1'b1;
            fwait(0, lat);
            chk("fix_single_lat", 32'(lat), 32'd2);
            frq[0] = 1'b0; step();
            frq[0] = 1'b1; frq[1] = 1'b1;
            fwait(2, lat);
            chk("fix_tie_lat", 32'(lat), 32'd2);
            chk("fix_tie_win0", 32'(f_ack0), 32'(1'b1));
            frq[0] = 1'b0;
            fwait(1, lat);
            chk("fix_next_p1", 32'(lat), 32'd2);
            frq[1] = 1'b0;
            step(); step();
            chk("fix_idle", 32'(f_busy), 32'(1'b0));
        end
        chk("fix_rdata", 32'({f_rdata1, f_rdata0}), 32'(16'h0000));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
